// File: rtl/alarm_melody_player.sv
// Alarm melody player: plays an 8-note ROM tune as a square wave while alarmOn is high.
// Define MELODY_LOOP_EN to repeat the tune; otherwise it plays once and waits for alarmOn to drop.
module alarm_melody_player #(
    parameter int unsigned CLK_HZ      = 5000000,
    parameter int unsigned BEAT_CYCLES = 1250000,
    parameter int unsigned GAP_CYCLES  = 125000
) (
    input  logic       fiveMhz,
    input  logic       reset,
    input  logic       alarmOn,
    output logic       pwmSound,
    output logic       pwmControl,
    output logic [9:0] currentNote
);

    localparam logic [22:0] ClkHz     = 23'(CLK_HZ);
    localparam logic [23:0] PlayLast1 = 24'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [23:0] PlayLast2 = 24'(2 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [23:0] GapLast   = 24'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StDivide, StPlay, StGap, StDone} state_e;

    state_e      state_q;
    logic [2:0]  idx_q;
    logic        two_q;
    logic [10:0] rem_q;
    logic [22:0] dvd_q;
    logic [4:0]  step_q;
    logic [23:0] dur_q;
    logic [23:0] gap_q;
    logic [22:0] tone_q;
    logic        sound_q;
    logic        ctrl_q;
    logic [9:0]  note_q;

    logic [9:0]  rom_freq;
    logic        rom_two;
    logic [11:0] divisor;
    logic [11:0] trial;
    logic        trial_ge;
    logic [23:0] play_last;

    always_comb begin
        rom_freq = 10'd0;
        rom_two  = 1'b0;
        case (idx_q)
            3'd0: rom_freq = 10'd523;
            3'd1: rom_freq = 10'd587;
            3'd2: rom_freq = 10'd659;
            3'd3: rom_freq = 10'd698;
            3'd4: begin rom_freq = 10'd784; rom_two = 1'b1; end
            3'd5: rom_freq = 10'd0;
            3'd6: rom_freq = 10'd880;
            3'd7: begin rom_freq = 10'd988; rom_two = 1'b1; end
            default: rom_freq = 10'd0;
        endcase
    end

    // Restoring divide step: HALF = CLK_HZ / (2*freq), quotient shifts into dvd_q.
    always_comb begin
        divisor   = {1'b0, note_q, 1'b0};
        trial     = {rem_q, dvd_q[22]};
        trial_ge  = (trial >= divisor);
        play_last = two_q ? PlayLast2 : PlayLast1;
    end

    always_ff @(posedge fiveMhz) begin
        if (reset || !alarmOn) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            two_q   <= 1'b0;
            rem_q   <= 11'd0;
            dvd_q   <= 23'd0;
            step_q  <= 5'd0;
            dur_q   <= 24'd0;
            gap_q   <= 24'd0;
            tone_q  <= 23'd0;
            sound_q <= 1'b0;
            ctrl_q  <= 1'b0;
            note_q  <= 10'd0;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StLoad;
                StLoad: begin
                    note_q  <= rom_freq;
                    two_q   <= rom_two;
                    rem_q   <= 11'd0;
                    dvd_q   <= ClkHz;
                    step_q  <= 5'd0;
                    dur_q   <= 24'd0;
                    tone_q  <= 23'd0;
                    sound_q <= 1'b0;
                    ctrl_q  <= 1'b0;
                    state_q <= (rom_freq != 10'd0) ? StDivide : StPlay;
                end
                StDivide: begin
                    rem_q  <= trial_ge ? 11'(trial - divisor) : trial[10:0];
                    dvd_q  <= {dvd_q[21:0], trial_ge};
                    step_q <= step_q + 5'd1;
                    if (step_q == 5'd22) begin
                        ctrl_q  <= 1'b1;
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    dur_q <= dur_q + 24'd1;
                    if (note_q != 10'd0) begin
                        if (tone_q == dvd_q - 23'd1) begin
                            tone_q  <= 23'd0;
                            sound_q <= ~sound_q;
                        end else begin
                            tone_q <= tone_q + 23'd1;
                        end
                    end
                    if (dur_q == play_last) begin
                        sound_q <= 1'b0;
                        ctrl_q  <= 1'b0;
                        gap_q   <= 24'd0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    gap_q <= gap_q + 24'd1;
                    if (gap_q == GapLast) begin
                        idx_q <= idx_q + 3'd1;
`ifdef MELODY_LOOP_EN
                        state_q <= StLoad;
`else
                        if (idx_q == 3'd7) begin
                            note_q  <= 10'd0;
                            state_q <= StDone;
                        end else begin
                            state_q <= StLoad;
                        end
`endif
                    end
                end
                StDone: state_q <= StDone;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pwmSound    = sound_q;
    assign pwmControl  = ctrl_q;
    assign currentNote = note_q;

endmodule

// File: tb/tb_alarm_melody_player.sv
// Bench for alarm_melody_player: per-cycle comparison against a timeline model of the melody.
// Honours MELODY_LOOP_EN the same way as the design.
module tb_alarm_melody_player;

    localparam int ClkHz = 500000;
    localparam int Beat  = 2000;
    localparam int Gap   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alarm = 1'b0;
    logic       snd;
    logic       ctl;
    logic [9:0] note;

    int n_vec = 0;
    int n_err = 0;
    int k = 0;

    always #5 clk = ~clk;

    alarm_melody_player #(
        .CLK_HZ     (ClkHz),
        .BEAT_CYCLES(Beat),
        .GAP_CYCLES (Gap)
    ) dut (
        .fiveMhz    (clk),
        .reset      (rst),
        .alarmOn    (alarm),
        .pwmSound   (snd),
        .pwmControl (ctl),
        .currentNote(note)
    );

    function automatic int tab_freq(input int i);
        case (i)
            0: return 523;
            1: return 587;
            2: return 659;
            3: return 698;
            4: return 784;
            5: return 0;
            6: return 880;
            7: return 988;
            default: return 0;
        endcase
    endfunction

    function automatic int tab_beats(input int i);
        return (i == 4 || i == 7) ? 2 : 1;
    endfunction

    // Edges from one note's LOAD edge to the next: divide + play + gap + load.
    function automatic int note_period(input int i);
        return ((tab_freq(i) != 0) ? 23 : 0) + tab_beats(i) * Beat + 1;
    endfunction

    function automatic int note_start(input int i);
        int s = 2;
        for (int j = 0; j < i; j++) s += note_period(j);
        return s;
    endfunction

    // Expected outputs after the kk-th edge, counting the edge that samples alarmOn as 1.
    function automatic void model(input int kk, output logic [9:0] en, output logic ec,
                                  output logic es);
        int s, idx, f, d, p, nxt;
        en = 10'd0;
        ec = 1'b0;
        es = 1'b0;
        if (kk < 2) return;
        s = 2;
        idx = 0;
        for (int it = 0; it < 64; it++) begin
            f = tab_freq(idx);
            d = (f != 0) ? 23 : 0;
            p = tab_beats(idx) * Beat - Gap;
            nxt = s + d + p + Gap + 1;
`ifndef MELODY_LOOP_EN
            if (idx == 7 && kk >= nxt - 1) return;
`endif
            if (kk < nxt) begin
                en = 10'(f);
                if (f != 0 && kk >= s + d && kk < s + d + p) begin
                    ec = 1'b1;
                    es = (((kk - s - d) / (ClkHz / (2 * f))) % 2) == 1;
                end
                return;
            end
            s = nxt;
            idx = (idx + 1) % 8;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic start_alarm();
        alarm = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alarm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({snd, ctl, note} !== 12'd0) begin
                n_err++;
                $display("FAIL reset cyc=%0d got snd=%b ctl=%b note=%0d want all 0", i, snd, ctl,
                         note);
            end
        end
        rst = 1'b0;
        alarm = 1'b0;
        tick();
        n_vec++;
        if ({snd, ctl, note} !== 12'd0) begin
            n_err++;
            $display("FAIL idle got snd=%b ctl=%b note=%0d want all 0", snd, ctl, note);
        end
    endtask

    task automatic test_first_note();
        logic [9:0] en;
        logic       ec, es;
        start_alarm();
        while (k < note_start(1) + 2) begin
            tick();
            model(k, en, ec, es);
            n_vec++;
            if (note !== en || ctl !== ec || snd !== es) begin
                n_err++;
                $display("FAIL first_note k=%0d got note=%0d ctl=%b snd=%b want %0d %b %b", k,
                         note, ctl, snd, en, ec, es);
            end
            if ((k == 2 && note !== 10'd523) || (k == 24 && ctl !== 1'b0) ||
                (k == 25 && ctl !== 1'b1) || (k == 25 + 478 && snd !== 1'b1)) begin
                n_err++;
                $display("FAIL first_note_timing k=%0d got note=%0d ctl=%b snd=%b", k, note, ctl,
                         snd);
            end
        end
        n_vec++;
        if (note !== 10'd587) begin
            n_err++;
            $display("FAIL second_note got %0d want 587", note);
        end
        alarm = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [9:0] en;
        logic       ec, es;
        int         target;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) target = note_start(2) + int'($urandom_range(0, note_period(2) - 1));
            else target = int'($urandom_range(1, 600));
            start_alarm();
            while (k < target) begin
                tick();
                model(k, en, ec, es);
                n_vec++;
                if (note !== en || ctl !== ec || snd !== es) begin
                    n_err++;
                    $display("FAIL abort_run r=%0d k=%0d got note=%0d ctl=%b snd=%b want %0d %b %b",
                             r, k, note, ctl, snd, en, ec, es);
                end
            end
            alarm = 1'b0;
            tick();
            n_vec++;
            if ({snd, ctl, note} !== 12'd0) begin
                n_err++;
                $display("FAIL abort_drop r=%0d got snd=%b ctl=%b note=%0d want all 0", r, snd,
                         ctl, note);
            end
            start_alarm();
            tick();
            tick();
            n_vec++;
            if (note !== 10'd523 || ctl !== 1'b0) begin
                n_err++;
                $display("FAIL abort_restart r=%0d got note=%0d ctl=%b want 523 0", r, note, ctl);
            end
            alarm = 1'b0;
            tick();
        end
    endtask

    task automatic test_melody();
        logic [9:0] en;
        logic       ec, es;
        start_alarm();
        while (k < note_start(8) + 300) begin
            tick();
            model(k, en, ec, es);
            n_vec++;
            if (note !== en || ctl !== ec || snd !== es) begin
                n_err++;
                $display("FAIL melody k=%0d got note=%0d ctl=%b snd=%b want %0d %b %b", k, note,
                         ctl, snd, en, ec, es);
            end
        end
        alarm = 1'b0;
        tick();
        n_vec++;
        if ({snd, ctl, note} !== 12'd0) begin
            n_err++;
            $display("FAIL melody_drop got snd=%b ctl=%b note=%0d want all 0", snd, ctl, note);
        end
        start_alarm();
        while (k < 30) begin
            tick();
            model(k, en, ec, es);
            n_vec++;
            if (note !== en || ctl !== ec || snd !== es) begin
                n_err++;
                $display("FAIL melody_replay k=%0d got note=%0d ctl=%b snd=%b want %0d %b %b", k,
                         note, ctl, snd, en, ec, es);
            end
        end
        alarm = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_divide();
        logic [9:0] en;
        logic       ec, es;
        int         target;
        target = note_start(6) + int'($urandom_range(0, 21));
        start_alarm();
        while (k < target) begin
            tick();
            model(k, en, ec, es);
            n_vec++;
            if (note !== en || ctl !== ec || snd !== es) begin
                n_err++;
                $display("FAIL rst_div_run k=%0d got note=%0d ctl=%b snd=%b want %0d %b %b", k,
                         note, ctl, snd, en, ec, es);
            end
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if ({snd, ctl, note} !== 12'd0) begin
            n_err++;
            $display("FAIL rst_div got snd=%b ctl=%b note=%0d want all 0", snd, ctl, note);
        end
        rst = 1'b0;
        k = 0;
        while (k < 40) begin
            tick();
            model(k, en, ec, es);
            n_vec++;
            if (note !== en || ctl !== ec || snd !== es) begin
                n_err++;
                $display("FAIL rst_div_restart k=%0d got note=%0d ctl=%b snd=%b want %0d %b %b", k,
                         note, ctl, snd, en, ec, es);
            end
        end
        alarm = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_abort();
        test_melody();
        test_reset_in_divide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
